// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch controller. It holds the program counter and the
// instruction register, and runs a single read transaction against
// instruction memory for each accepted fetch request. A read that gets no
// mem_ready within MAX_WAIT cycles locks the block into a sticky FAULT state.
// Only reset leaves that state.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   fetch_req  in   fetch the next instruction (sampled in IDLE only)
//   jump       in   load pc from jump_addr (sampled in IDLE only)
//   jump_addr  in   jump target
//   mem_addr   out  read address (always equal to pc)
//   mem_read   out  read strobe, high in READ
//   mem_ready  in   read data valid this cycle
//   mem_data   in   read data
//   opcode     out  upper OPCODE_WIDTH bits of ir
//   operand    out  remaining low bits of ir
//   pc         out  current program counter
//   ir_valid   out  ir holds a completed fetch
//   busy       out  high in READ and FAULT
//   fault      out  read timeout occurred, sticky until reset
//
// Every output comes from a register or from a decode of the state
// register. No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int OPCODE_WIDTH = 7,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int RESET_PC     = 0,
  parameter int MAX_WAIT     = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               fetch_req,
  input  logic                               jump,
  input  logic [ADDR_WIDTH-1:0]              jump_addr,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_read,
  input  logic                               mem_ready,
  input  logic [DATA_WIDTH-1:0]              mem_data,
  output logic [OPCODE_WIDTH-1:0]            opcode,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic [ADDR_WIDTH-1:0]              pc,
  output logic                               ir_valid,
  output logic                               busy,
  output logic                               fault
);

  // The wait counter only needs to reach MAX_WAIT-1. The read times out on
  // the cycle that finds the counter at that value with no mem_ready.
  localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;

  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [DATA_WIDTH-1:0]   ir_r;
  logic                    ir_valid_r;
  logic                    fault_r;
  logic [WAIT_W-1:0]       wait_cnt_r;

  // Control strobes decoded from the current state and inputs
  logic                    load_jump_s;
  logic                    start_s;
  logic                    complete_s;
  logic                    wait_inc_s;
  logic                    timeout_s;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, control strobes and state-decoded outputs
  always_comb begin
    state_nxt_s = state_r;
    load_jump_s = 1'b0;
    start_s     = 1'b0;
    complete_s  = 1'b0;
    wait_inc_s  = 1'b0;
    timeout_s   = 1'b0;
    mem_read    = 1'b0;
    busy        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Jump and fetch together: pc takes jump_addr on this edge, so the
        // first READ cycle already presents the jump target.
        load_jump_s = jump;
        if (fetch_req) begin
          start_s     = 1'b1;
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_READ: begin
        mem_read = 1'b1;
        busy     = 1'b1;
        // mem_ready takes priority. Data arriving on the last allowed
        // cycle completes the read instead of faulting.
        if (mem_ready) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_FAULT;
        end else begin
          wait_inc_s  = 1'b1;
          state_nxt_s = ST_READ;
        end
      end

      ST_FAULT: begin
        busy        = 1'b1;
        state_nxt_s = ST_FAULT;
      end

      default: begin
        // An illegal encoding recovers to IDLE.
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Program counter: jump load in IDLE, increment on read completion
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= PC_INIT;
    end else if (complete_s) begin
      pc_r <= pc_r + PC_ONE;
    end else if (load_jump_s) begin
      pc_r <= jump_addr;
    end
  end

  // Instruction register. It keeps the old word until a read completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_r <= {DATA_WIDTH{1'b0}};
    end else if (complete_s) begin
      ir_r <= mem_data;
    end
  end

  // ir_valid: cleared when a fetch starts, set when it completes
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_valid_r <= 1'b0;
    end else if (complete_s) begin
      ir_valid_r <= 1'b1;
    end else if (start_s) begin
      ir_valid_r <= 1'b0;
    end
  end

  // Wait counter: consecutive READ cycles without mem_ready
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (start_s) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (wait_inc_s) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end
  end

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_r <= 1'b0;
    end else if (timeout_s) begin
      fault_r <= 1'b1;
    end
  end

  assign mem_addr = pc_r;
  assign pc       = pc_r;
  assign opcode   = ir_r[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand  = ir_r[DATA_WIDTH-OPCODE_WIDTH-1:0];
  assign ir_valid = ir_valid_r;
  assign fault    = fault_r;

endmodule
